coin_collector: RTL and testbench
=================================

# coin_collector

Front-end credit stage that sits directly upstream of the food-seller core. Accepts coin pulses, accumulates a saturating 3-bit credit, latches the customer's item choice, and presents a stable `{choice, money}` order to the seller under a valid/ready handshake. Handles cancel and inactivity timeout by refunding credit one unit per cycle.

## Interface
- `CREDIT_MAX`, 7: maximum credit in units; must fit in `MONEY_W`.
- `MONEY_W`, 3: width of credit and `money` output; matches the seller's `money` input.
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before auto-refund (used only with `COIN_TIMEOUT_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `coin_valid` in 1: one-cycle strobe; coin present.
- `coin_code` in 2: 0 = invalid, 1 = 1 unit, 2 = 2 units, 3 = 5 units.
- `sel` in 3: item request; 0 = none, 1..7 = item code.
- `cancel` in 1: request refund.
- `order_ready` in 1: seller accepts the current order.
- `choice` out 3: latched item code to seller.
- `money` out `MONEY_W`: credit to seller.
- `order_valid` out 1: order presented.
- `coin_reject` out 1: one-cycle pulse; coin returned unaccepted.
- `refund_pulse` out 1: one unit returned this cycle.
- `credit` out `MONEY_W`: live credit, for display.

## Operation
- States: IDLE (credit 0), COLLECT (credit > 0), ORDER (order_valid high), REFUND.
- Coin: value v = decode(coin_code). Accepted only in IDLE/COLLECT when `credit + v <= CREDIT_MAX`; credit += v, and IDLE moves to COLLECT. Otherwise, including code 0, ORDER, REFUND, or overflow, `coin_reject` pulses next cycle and credit is unchanged. Never wrap or saturate silently.
- Choice: in COLLECT, `sel != 0` latches `choice` and moves to ORDER. In IDLE, `sel` is ignored.
- Coin and `sel` in the same COLLECT cycle: coin is credited first; the order presents the updated credit.
- ORDER: `order_valid`=1; `choice`/`money` are held stable until `order_ready`. On `order_ready`, credit is cleared to 0 and the state returns to IDLE. The seller owns change computation. `cancel` and coins are ignored/rejected in ORDER.
- `cancel` in COLLECT moves to REFUND. `cancel` wins over a simultaneous `sel`. A simultaneous coin is rejected. `cancel` in IDLE is a no-op.
- REFUND: each cycle `refund_pulse`=1 and credit -= 1. When credit reaches 0, the state returns to IDLE.
- `choice` and `money` are 0 whenever `order_valid`=0.

## Timing
- Reset values: state IDLE; `credit`, `money`, `choice` = 0; `order_valid`, `coin_reject`, `refund_pulse` = 0. Reset mid-operation discards credit with no refund pulses.
- Coin to credit update: 1 cycle. `coin_reject`: 1-cycle pulse, 1 cycle after the strobe.
- `sel` sampled at edge N gives `order_valid`=1 from N+1.
- Handshake completes on the edge where `order_valid && order_ready`. `order_valid`=0 the following cycle. `order_ready` without `order_valid` is ignored.
- Refund of N units: exactly N consecutive `refund_pulse` cycles starting the cycle after `cancel`; IDLE on the next cycle.

## Configuration
- `COIN_TIMEOUT_EN` defined: a counter runs in COLLECT and resets on any accepted coin. Reaching `TIMEOUT_CYCLES` enters REFUND exactly as if `cancel` had been asserted. The counter is cleared outside COLLECT.
- Not defined: no counter is built; COLLECT waits indefinitely.

## Structure
- Shared package `coin_pkg`: state enum, coin code constants, `coin_value()` decode function, default `CREDIT_MAX`/`MONEY_W`.
- One sub-module: `idle_timer`, parameterised on `TIMEOUT_CYCLES`, with inputs `clear` and `run` and output `expired`. It is instantiated only under `COIN_TIMEOUT_EN`.

## Test plan
- Reset, then coins code 2 and code 3 (7 units), then `sel`=1 → `order_valid`=1, `choice`=1, `money`=7; `order_ready` → next cycle credit 0, IDLE.
- Credit 5, then coin code 3 → `coin_reject` pulse, credit stays 5; coin code 2 → credit 7.
- Credit 3, `cancel` together with `sel`=3 → 3 `refund_pulse` cycles, no order, IDLE.
- In ORDER with `order_ready` low for 10 cycles, plus a coin and `cancel` → `choice`/`money` stable, coin rejected, no refund.
- `rst` asserted asynchronously mid-REFUND (credit 2) → all outputs 0 immediately, no further `refund_pulse`.
- With `COIN_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20: credit 1, idle for 20 cycles → REFUND with 1 pulse. A coin at cycle 15 restarts the count.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin collector: FSM state encoding,
// coin codes, coin value decode and default sizing.
package coin_pkg;

  localparam int DEF_CREDIT_MAX = 7;
  localparam int DEF_MONEY_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ORDER,
    ST_REFUND
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_ONE  = 2'd1;
  localparam logic [1:0] COIN_TWO  = 2'd2;
  localparam logic [1:0] COIN_FIVE = 2'd3;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_ONE:  coin_value = 3'd1;
      COIN_TWO:  coin_value = 3'd2;
      COIN_FIVE: coin_value = 3'd5;
      default:   coin_value = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Inactivity counter: counts cycles while run is high, cleared by clear,
// and flags expired during the last cycle of a TIMEOUT_CYCLES-long run.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (run)
      cnt <= cnt + CNT_W'(1);
  end

  // Independent of clear so a coin in the expiring cycle cannot feed back into expiry.
  assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/coin_collector.sv
// Coin credit front-end for the food seller: accumulates credit, latches the
// item choice, presents {choice, money} under valid/ready, refunds on cancel.
// Optional inactivity auto-refund is built when COIN_TIMEOUT_EN is defined.
module coin_collector
  import coin_pkg::*;
#(
  parameter int CREDIT_MAX     = DEF_CREDIT_MAX,
  parameter int MONEY_W        = DEF_MONEY_W,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               coin_valid,
  input  logic [1:0]         coin_code,
  input  logic [2:0]         sel,
  input  logic               cancel,
  input  logic               order_ready,
  output logic [2:0]         choice,
  output logic [MONEY_W-1:0] money,
  output logic               order_valid,
  output logic               coin_reject,
  output logic               refund_pulse,
  output logic [MONEY_W-1:0] credit
);

  localparam int SUM_W = MONEY_W + 3;
  localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'(CREDIT_MAX);

  state_t             state, next_state;
  logic [MONEY_W-1:0] credit_next;
  logic [2:0]         choice_r, choice_next;
  logic [SUM_W-1:0]   sum;
  logic               coin_ok, abort, expired, timer_clear;

`ifdef COIN_TIMEOUT_EN
  assign timer_clear = (state != ST_COLLECT) || coin_ok;

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .run    (state == ST_COLLECT),
    .expired(expired)
  );
`else
  assign timer_clear = 1'b0;
  assign expired     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      credit      <= '0;
      choice_r    <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= next_state;
      credit      <= credit_next;
      choice_r    <= choice_next;
      coin_reject <= coin_valid && !coin_ok;
    end
  end

  always_comb begin
    next_state  = state;
    credit_next = credit;
    choice_next = choice_r;
    sum         = SUM_W'(credit) + SUM_W'(coin_value(coin_code));
    abort       = (state == ST_COLLECT) && (cancel || expired);
    // Overflow is a rejection, never a wrap or silent clamp.
    coin_ok     = coin_valid && (coin_code != COIN_NONE) && (sum <= MAX_EXT) &&
                  ((state == ST_IDLE) || ((state == ST_COLLECT) && !abort));
    case (state)
      ST_IDLE: begin
        if (coin_ok) begin
          credit_next = sum[MONEY_W-1:0];
          next_state  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (abort) begin
          next_state = ST_REFUND;
        end else begin
          if (coin_ok)
            credit_next = sum[MONEY_W-1:0];
          if (sel != 3'd0) begin
            choice_next = sel;
            next_state  = ST_ORDER;
          end
        end
      end
      ST_ORDER: begin
        if (order_ready) begin
          credit_next = '0;
          choice_next = '0;
          next_state  = ST_IDLE;
        end
      end
      ST_REFUND: begin
        credit_next = credit - MONEY_W'(1);
        if (credit <= MONEY_W'(1))
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign order_valid  = (state == ST_ORDER);
  assign refund_pulse = (state == ST_REFUND);
  assign money        = order_valid ? credit : '0;
  assign choice       = order_valid ? choice_r : 3'd0;

endmodule

// File: tb/tb_coin_collector.sv
// Directed self-checking bench for coin_collector; the timeout scenario is
// exercised when COIN_TIMEOUT_EN is defined, otherwise the no-timeout behaviour.
module tb_coin_collector;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic [2:0] sel;
  logic       cancel;
  logic       order_ready;
  logic [2:0] choice;
  logic [2:0] money;
  logic       order_valid;
  logic       coin_reject;
  logic       refund_pulse;
  logic [2:0] credit;

  int checks = 0;
  int errors = 0;

  coin_collector #(
    .CREDIT_MAX(7),
    .MONEY_W(3),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_code   (coin_code),
    .sel         (sel),
    .cancel      (cancel),
    .order_ready (order_ready),
    .choice      (choice),
    .money       (money),
    .order_valid (order_valid),
    .coin_reject (coin_reject),
    .refund_pulse(refund_pulse),
    .credit      (credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_code  = code;
    step();
    coin_valid = 1'b0;
    coin_code  = 2'd0;
  endtask

  initial begin
    rst = 1'b1; coin_valid = 0; coin_code = 0; sel = 0; cancel = 0; order_ready = 0;
    #12;
    chk("rst_credit", credit, 0);
    chk("rst_valid", order_valid, 0);
    chk("rst_money", money, 0);
    chk("rst_choice", choice, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_refund", refund_pulse, 0);
    step();
    rst = 1'b0;

    // IDLE ignores cancel and sel
    cancel = 1; sel = 2; step(); cancel = 0; sel = 0;
    chk("idle_cancel_refund", refund_pulse, 0);
    chk("idle_sel_valid", order_valid, 0);

    // 2 + 5 units, order item 1, handshake
    coin(2'd2);
    chk("t1_credit2", credit, 2);
    coin(2'd3);
    chk("t1_credit7", credit, 7);
    chk("t1_noreject", coin_reject, 0);
    sel = 1; step(); sel = 0;
    chk("t1_valid", order_valid, 1);
    chk("t1_choice", choice, 1);
    chk("t1_money", money, 7);
    order_ready = 1; step(); order_ready = 0;
    chk("t1_done_valid", order_valid, 0);
    chk("t1_done_credit", credit, 0);
    chk("t1_done_money", money, 0);

    // overflow rejection, then exact fill to max
    coin(2'd3);
    chk("t2_credit5", credit, 5);
    coin(2'd3);
    chk("t2_reject", coin_reject, 1);
    chk("t2_kept5", credit, 5);
    step();
    chk("t2_reject_pulse", coin_reject, 0);
    coin(2'd2);
    chk("t2_credit7", credit, 7);
    chk("t2_accept", coin_reject, 0);
    cancel = 1; step(); cancel = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t2_refund", refund_pulse, (i < 7) ? 1 : 0);
      chk("t2_refund_credit", credit, 7 - i);
      step();
    end

    // code 0 is rejected
    coin(2'd0);
    chk("code0_reject", coin_reject, 1);
    chk("code0_credit", credit, 0);

    // cancel beats simultaneous sel: 3 pulses, no order
    coin(2'd1);
    coin(2'd2);
    chk("t3_credit3", credit, 3);
    cancel = 1; sel = 3; step(); cancel = 0; sel = 0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_refund", refund_pulse, (i < 3) ? 1 : 0);
      chk("t3_noorder", order_valid, 0);
      step();
    end
    chk("t3_idle_credit", credit, 0);

    // ORDER stalled 10 cycles with a coin and cancel in the middle
    coin(2'd3);
    sel = 4; step(); sel = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        coin_valid = 1; coin_code = 2'd1; cancel = 1;
      end
      step();
      coin_valid = 0; coin_code = 0; cancel = 0;
      chk("t4_valid", order_valid, 1);
      chk("t4_choice", choice, 4);
      chk("t4_money", money, 5);
      chk("t4_refund", refund_pulse, 0);
      chk("t4_reject", coin_reject, (i == 3) ? 1 : 0);
    end
    order_ready = 1; step(); order_ready = 0;
    chk("t4_done", order_valid, 0);

    // async reset in the middle of a refund
    coin(2'd3);
    cancel = 1; step(); cancel = 0;
    step(); step(); step();
    chk("t5_pre_refund", refund_pulse, 1);
    chk("t5_pre_credit", credit, 2);
    #2 rst = 1;
    #1;
    chk("t5_rst_refund", refund_pulse, 0);
    chk("t5_rst_credit", credit, 0);
    chk("t5_rst_valid", order_valid, 0);
    #3 rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_after_refund", refund_pulse, 0);
      chk("t5_after_credit", credit, 0);
    end

`ifdef COIN_TIMEOUT_EN
    // coin after 14 idle cycles restarts the 20-cycle count
    coin(2'd1);
    for (int i = 0; i < 14; i++) step();
    chk("t6_mid_refund", refund_pulse, 0);
    coin(2'd1);
    chk("t6_credit2", credit, 2);
    for (int i = 0; i < 19; i++) begin
      chk("t6_wait_refund", refund_pulse, 0);
      step();
    end
    step();
    chk("t6_refund1", refund_pulse, 1);
    chk("t6_refund1_credit", credit, 2);
    step();
    chk("t6_refund2", refund_pulse, 1);
    step();
    chk("t6_end_refund", refund_pulse, 0);
    chk("t6_end_credit", credit, 0);
`else
    // without the timer COLLECT waits indefinitely
    coin(2'd1);
    for (int i = 0; i < 30; i++) step();
    chk("t6_no_timeout_refund", refund_pulse, 0);
    chk("t6_no_timeout_credit", credit, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
